// File: rtl/joy_db15_tx.sv
// joy_db15_tx: responder side of the DB15 serial joystick link.
// Emulates the shift-register controller adapter. The joystick master strobes
// JOY_LOAD and then clocks JOY_CLK; the adapter answers on JOY_DATA.
// A LOAD strobe snapshots two players' button words. Each JOY_CLK rising edge
// then shifts one bit out, active-low.
// Ports:
//   clk        joystick clock (40-50 MHz)
//   reset      asynchronous, active-high
//   joystick1  player 1 buttons, active-high (bit0=R,1=L,2=D,3=U,4..=fire)
//   joystick2  player 2 buttons, same mapping
//   JOY_LOAD   parallel-load strobe from master, async, active-high
//   JOY_CLK    shift clock from master, async, shift on rising edge
//   JOY_DATA   serial data, active-low, registered
//   busy       high while loading or shifting
//   frame_done one-cycle pulse when the last bit of a frame has been shifted
//   timeout    one-cycle pulse when a frame is abandoned for lack of clocks
module joy_db15_tx #(
    parameter int unsigned BITS        = 12,
    parameter int unsigned TIMEOUT     = 65535,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] joystick1,
    input  logic [15:0] joystick2,
    input  logic        JOY_LOAD,
    input  logic        JOY_CLK,
    output logic        JOY_DATA,
    output logic        busy,
    output logic        frame_done,
    output logic        timeout
);

    localparam int unsigned FRAME_W = 2 * BITS;
    localparam int unsigned CNT_W   = 6;
    localparam int unsigned TMO_W   = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(FRAME_W);
    localparam logic [TMO_W-1:0] TMO_MAX   = TMO_W'(TIMEOUT);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    logic [SYNC_STAGES-1:0] load_sync;
    logic [SYNC_STAGES-1:0] jclk_sync;
    logic                   jclk_prev;

    logic [1:0]         state,  state_n;
    logic [FRAME_W-1:0] shreg,  shreg_n;
    logic [CNT_W-1:0]   count,  count_n;
    logic [TMO_W-1:0]   tcnt,   tcnt_n;
    logic               data_n;
    logic               done_n;
    logic               to_n;

    logic               load_s_c;
    logic               jclk_rise_c;
    logic [FRAME_W-1:0] snapshot_c;
    logic [FRAME_W-1:0] shifted_c;
    logic [CNT_W-1:0]   count_inc_c;
    logic [TMO_W-1:0]   tcnt_inc_c;

    // Upper button bits beyond BITS are intentionally not serialised.
    logic unused_joy;
    assign unused_joy = &{1'b0, joystick1, joystick2};

    assign load_s_c    = load_sync[SYNC_STAGES-1];
    assign jclk_rise_c = jclk_sync[SYNC_STAGES-1] & ~jclk_prev;

    // Wire format is active-low; player 1 goes out first, LSB first.
    assign snapshot_c  = ~{joystick2[BITS-1:0], joystick1[BITS-1:0]};
    assign shifted_c   = {1'b1, shreg[FRAME_W-1:1]};
    assign count_inc_c = count + CNT_W'(1);
    // Saturating; the FSM leaves SHIFT as soon as TMO_MAX is reached.
    assign tcnt_inc_c  = (tcnt == TMO_MAX) ? tcnt : tcnt + TMO_W'(1);

    // Synchronisers for the asynchronous master strobes plus edge-detect flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_sync <= '0;
            jclk_sync <= '0;
            jclk_prev <= 1'b0;
        end else begin
            load_sync <= {load_sync[SYNC_STAGES-2:0], JOY_LOAD};
            jclk_sync <= {jclk_sync[SYNC_STAGES-2:0], JOY_CLK};
            jclk_prev <= jclk_sync[SYNC_STAGES-1];
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            shreg      <= '1;
            count      <= '0;
            tcnt       <= '0;
            JOY_DATA   <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            count      <= count_n;
            tcnt       <= tcnt_n;
            JOY_DATA   <= data_n;
            busy       <= (state_n != ST_IDLE);
            frame_done <= done_n;
            timeout    <= to_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        count_n = count;
        tcnt_n  = tcnt;
        data_n  = JOY_DATA;
        done_n  = 1'b0;
        to_n    = 1'b0;

        case (state)
            ST_IDLE: begin
                data_n  = 1'b1;
                count_n = '0;
                tcnt_n  = '0;
                if (load_s_c) begin
                    state_n = ST_LOAD;
                    shreg_n = snapshot_c;
                    data_n  = snapshot_c[0];
                end
            end

            ST_LOAD: begin
                count_n = '0;
                tcnt_n  = '0;
                // Track the buttons until the strobe drops, which freezes the snapshot.
                if (load_s_c) begin
                    shreg_n = snapshot_c;
                    data_n  = snapshot_c[0];
                end else begin
                    state_n = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                // Load has priority over a coincident clock edge.
                if (load_s_c) begin
                    state_n = ST_LOAD;
                    shreg_n = snapshot_c;
                    data_n  = snapshot_c[0];
                    count_n = '0;
                    tcnt_n  = '0;
                end else if (jclk_rise_c) begin
                    shreg_n = shifted_c;
                    count_n = count_inc_c;
                    tcnt_n  = '0;
                    if (count_inc_c == FRAME_LEN) begin
                        done_n  = 1'b1;
                        data_n  = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        data_n  = shifted_c[0];
                    end
                end else begin
                    tcnt_n = tcnt_inc_c;
                    if (tcnt_inc_c == TMO_MAX) begin
                        to_n    = 1'b1;
                        data_n  = 1'b1;
                        state_n = ST_IDLE;
                    end
                end
            end

            default: begin
                state_n = ST_IDLE;
                data_n  = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_joy_db15_tx.sv
// tb_joy_db15_tx: directed bench for joy_db15_tx.
// Expected serial bits are pushed to a queue when a load is driven and popped
// as each JOY_CLK phase completes.
module tb_joy_db15_tx;

    localparam int unsigned BITS = 12;
    localparam int unsigned TMO  = 100;
    localparam int unsigned SYNC = 2;
    localparam int unsigned HALF = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] joystick1;
    logic [15:0] joystick2;
    logic        JOY_LOAD;
    logic        JOY_CLK;
    logic        JOY_DATA;
    logic        busy;
    logic        frame_done;
    logic        timeout;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   done_cnt = 0;
    int   to_cnt   = 0;
    int   done_cyc = -1;
    int   to_cyc   = -1;
    int   rise_cyc = 0;
    int   idle_bad = 0;
    logic done_busy;
    logic exp_q[$];

    always #5 clk = ~clk;

    joy_db15_tx #(
        .BITS        (BITS),
        .TIMEOUT     (TMO),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .joystick1  (joystick1),
        .joystick2  (joystick2),
        .JOY_LOAD   (JOY_LOAD),
        .JOY_CLK    (JOY_CLK),
        .JOY_DATA   (JOY_DATA),
        .busy       (busy),
        .frame_done (frame_done),
        .timeout    (timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs sampled on the falling edge, pulses recorded.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (frame_done === 1'b1) begin
            done_cnt++;
            done_cyc  = cyc;
            done_busy = busy;
        end
        if (timeout === 1'b1) begin
            to_cnt++;
            to_cyc = cyc;
        end
    endtask

    task automatic clear_counts();
        done_cnt  = 0;
        to_cnt    = 0;
        done_cyc  = -1;
        to_cyc    = -1;
        done_busy = 1'bx;
    endtask

    function automatic logic wire_bit(input logic [15:0] j1, input logic [15:0] j2, input int k);
        if (k < int'(BITS)) return ~j1[k];
        return ~j2[k - int'(BITS)];
    endfunction

    task automatic do_load(input logic [15:0] j1, input logic [15:0] j2);
        joystick1 = j1;
        joystick2 = j2;
        JOY_LOAD  = 1'b1;
        repeat (HALF) tick();
        JOY_LOAD  = 1'b0;
        exp_q.delete();
        for (int k = 0; k < int'(2 * BITS); k++) exp_q.push_back(wire_bit(j1, j2, k));
        exp_q.push_back(1'b1);
        repeat (HALF) tick();
    endtask

    task automatic check_bit(input string tag);
        logic e;
        e = (exp_q.size() == 0) ? 1'b1 : exp_q.pop_front();
        chk(tag, 32'(JOY_DATA), 32'(e));
    endtask

    task automatic rise(input string tag);
        JOY_CLK  = 1'b1;
        rise_cyc = cyc;
        repeat (HALF) tick();
        check_bit(tag);
        JOY_CLK  = 1'b0;
        repeat (HALF) tick();
    endtask

    initial begin
        reset     = 1'b1;
        joystick1 = '0;
        joystick2 = '0;
        JOY_LOAD  = 1'b0;
        JOY_CLK   = 1'b0;
        clear_counts();
        repeat (3) tick();
        chk("rst_data", 32'(JOY_DATA), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_tmo",  32'(timeout), 32'd0);
        reset = 1'b0;

        // Quiet link: released line, never busy, no pulses.
        repeat (10000) begin
            tick();
            if (JOY_DATA !== 1'b1 || busy !== 1'b0) idle_bad++;
        end
        chk("idle_bad",  32'(idle_bad), 32'd0);
        chk("idle_done", 32'(done_cnt), 32'd0);
        chk("idle_tmo",  32'(to_cnt), 32'd0);

        // Clock edges with no load are ignored.
        for (int i = 1; i <= 3; i++) rise($sformatf("idle_rise%0d", i));
        chk("idle_rise_busy", 32'(busy), 32'd0);

        // Full frame; buttons changed during shifting must not leak in.
        clear_counts();
        do_load(16'h0011, 16'h0802);
        chk("f1_busy", 32'(busy), 32'd1);
        check_bit("f1_bit0");
        joystick1 = 16'hFFFF;
        joystick2 = 16'hFFFF;
        for (int i = 1; i <= int'(2 * BITS); i++) rise($sformatf("f1_rise%0d", i));
        chk("f1_done_cnt", 32'(done_cnt), 32'd1);
        chk("f1_done_lat", 32'(done_cyc - rise_cyc), 32'(SYNC + 1));
        chk("f1_done_busy", 32'(done_busy), 32'd0);
        chk("f1_busy_end", 32'(busy), 32'd0);
        chk("f1_tmo", 32'(to_cnt), 32'd0);

        // Master stops after 10 clocks: frame abandoned after TMO idle cycles.
        clear_counts();
        do_load(16'h0011, 16'h0802);
        check_bit("to_bit0");
        for (int i = 1; i <= 10; i++) rise($sformatf("to_rise%0d", i));
        repeat (120) tick();
        chk("to_cnt", 32'(to_cnt), 32'd1);
        chk("to_lat", 32'(to_cyc - rise_cyc), 32'(SYNC + 1 + TMO));
        chk("to_data", 32'(JOY_DATA), 32'd1);
        chk("to_busy", 32'(busy), 32'd0);
        chk("to_done", 32'(done_cnt), 32'd0);

        // Reload mid-frame with new buttons: silent abort, fresh snapshot.
        clear_counts();
        do_load(16'h0011, 16'h0802);
        check_bit("ab_bit0");
        for (int i = 1; i <= 5; i++) rise($sformatf("ab_rise%0d", i));
        do_load(16'h0001, 16'h0802);
        chk("ab_done0", 32'(done_cnt), 32'd0);
        chk("ab_tmo0",  32'(to_cnt), 32'd0);
        check_bit("ab2_bit0");
        for (int i = 1; i <= int'(2 * BITS); i++) rise($sformatf("ab2_rise%0d", i));
        chk("ab2_done", 32'(done_cnt), 32'd1);
        chk("ab2_tmo",  32'(to_cnt), 32'd0);

        // Extra clocks past the frame read released.
        clear_counts();
        do_load(16'h0011, 16'h0802);
        check_bit("x_bit0");
        for (int i = 1; i <= 30; i++) rise($sformatf("x_rise%0d", i));
        chk("x_done", 32'(done_cnt), 32'd1);
        chk("x_busy", 32'(busy), 32'd0);

        // Reset mid-frame at bit 7, then a clean frame.
        clear_counts();
        do_load(16'h0080, 16'h0000);
        check_bit("r_bit0");
        for (int i = 1; i <= 7; i++) rise($sformatf("r_rise%0d", i));
        #2;
        reset = 1'b1;
        #1;
        chk("r_async_data", 32'(JOY_DATA), 32'd1);
        chk("r_async_busy", 32'(busy), 32'd0);
        tick();
        reset = 1'b0;
        repeat (4) tick();
        chk("r_done", 32'(done_cnt), 32'd0);
        chk("r_tmo",  32'(to_cnt), 32'd0);
        do_load(16'h0011, 16'h0802);
        check_bit("r2_bit0");
        for (int i = 1; i <= int'(2 * BITS); i++) rise($sformatf("r2_rise%0d", i));
        chk("r2_done", 32'(done_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/joy_db15_tx.md
Name: joy_db15_tx

Overview:
- Responder side of the DB15 serial joystick link: emulates the external shift-register controller adapter that the joystick master clocks.
- Snapshots two players' button words on JOY_LOAD, then shifts them out one bit per JOY_CLK rising edge on JOY_DATA.
- Used in loop-back benches and in the board-to-board bridge where the core acts as a controller adapter toward another MiSTer.
- Runs on CLK_JOY (40-50 MHz); JOY_CLK/JOY_LOAD are asynchronous and synchronised internally.

Parameters:
- BITS, 12, buttons per player serialised (1..16); frame length = 2*BITS.
- TIMEOUT, 65535, clk cycles without JOY_CLK edge in SHIFT before abandoning the frame.
- SYNC_STAGES, 2, synchroniser flops on JOY_CLK and JOY_LOAD (>=2).

Ports:
- clk  in  1  joystick clock, 40-50 MHz.
- reset  in  1  asynchronous, active-high.
- joystick1  in  16  player 1 buttons, active-high, bit0=R, 1=L, 2=D, 3=U, 4.. = fire buttons.
- joystick2  in  16  player 2 buttons, same mapping.
- JOY_LOAD  in  1  parallel-load strobe from master, active-high, async.
- JOY_CLK  in  1  shift clock from master, async; shift on rising edge.
- JOY_DATA  out  1  serial data, active-low (0 = pressed), registered.
- busy  out  1  high in LOAD or SHIFT.
- frame_done  out  1  one-cycle pulse when the last bit of a frame has been shifted.
- timeout  out  1  one-cycle pulse when a SHIFT frame is abandoned.

Behaviour:
- Reset (async): state IDLE, shift register all-ones (released), bit count 0, timeout counter 0, JOY_DATA=1, busy=0, frame_done=0, timeout=0.
- Inputs pass through SYNC_STAGES flops, then a one-flop edge detector. JOY_CLK rise-to-JOY_DATA update latency is SYNC_STAGES+1 clk cycles (3 by default). The master must keep each JOY_CLK phase at least SYNC_STAGES+1 cycles.
- Serial order: bits 0..BITS-1 are joystick1[0..BITS-1], then bits BITS..2*BITS-1 are joystick2[0..BITS-1]. Each bit is inverted on the wire.
- IDLE:
  - JOY_DATA=1.
  - Synced JOY_LOAD high -> LOAD.
- LOAD:
  - Every cycle, reload the shift register with the inverted concatenation {~joystick2[BITS-1:0], ~joystick1[BITS-1:0]}, so the latest value is held.
  - JOY_DATA = bit 0 (~joystick1[0]); count=0.
  - JOY_CLK edges are ignored.
  - Synced JOY_LOAD falls -> SHIFT; the snapshot is frozen at the last LOAD cycle.
- SHIFT:
  - On each synced JOY_CLK rising edge: shift right, fill with 1, count+1, JOY_DATA = new bit 0, clear the timeout counter.
  - When count reaches 2*BITS: frame_done pulse in the same cycle, JOY_DATA=1, -> IDLE.
  - With no edge, the timeout counter increments. On reaching TIMEOUT: timeout pulse, JOY_DATA=1, -> IDLE.
  - Synced JOY_LOAD high: abort silently (no pulse) -> LOAD.
- Extra JOY_CLK edges in IDLE are ignored; JOY_DATA stays 1 (released).
- JOY_LOAD rise and JOY_CLK rise in the same synced cycle: load wins, the clock edge is dropped.
- Count width is 6 bits and never wraps; the timeout counter saturates at TIMEOUT.
- busy = (state != IDLE), registered with the state.
- Reset asserted mid-frame: immediate return to IDLE values; no frame_done/timeout pulse.
- joystick1/joystick2 are sampled only in LOAD; changes during SHIFT do not affect the current frame.

Test Plan:
- Reset, no stimulus -> JOY_DATA=1, busy=0, no pulses for 10000 cycles.
- joystick1=16'h0011, joystick2=16'h0802; JOY_LOAD pulse of 8 cycles; 24 JOY_CLK periods of 8 cycles high / 8 cycles low -> captured bits (before the first rise, then after each rise):
  - pressed (0) at serial bit 0 (P1 R), bit 4 (P1 fire1), bit 13 (P2 L), bit 23 (P2 bit11);
  - all other bits 1;
  - frame_done pulses once on the 24th rise; busy drops the same cycle.
- Same setup, stop after 10 clocks with TIMEOUT=100 -> timeout pulses 100 cycles after the 10th synced rise; JOY_DATA=1; frame_done never pulses.
- Re-assert JOY_LOAD after 5 clocks, with joystick1 changed to 16'h0001 -> new frame starts at bit 0 with the new snapshot; no frame_done/timeout for the aborted frame.
- 30 clocks after load with BITS=12 -> bits 24..29 read 1; exactly one frame_done pulse.
- Assert reset at bit 7 -> JOY_DATA=1 and busy=0 asynchronously; the next load produces a correct full frame.
